// File: rtl/norm_stream_pkg.sv
// Shared types and width helpers for the norm_stream pixel normaliser.
package norm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_WAIT_UP = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4
  } norm_state_t;

  function automatic int coef_frac(input int pw);
    return 2 * pw;
  endfunction

  function automatic int coef_width(input int pw);
    return coef_frac(pw) + 1;
  endfunction

  // Right shift that turns pix*coef (COEF_FRAC fraction bits) into OUT_FRAC fraction bits.
  function automatic int round_shift(input int pw, input int fp_int);
    return coef_frac(pw) - (pw - fp_int);
  endfunction

endpackage

// File: rtl/norm_stream_if.sv
// AXI-Stream style beat bundle (valid/ready/data/user/last) used on both sides of norm_stream.
interface norm_stream_if #(
  parameter int DATA_W = 40,
  parameter int USER_W = 2
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);

endinterface

// File: rtl/norm_stream_recip.sv
// Restoring serial divider: coef = floor(2^(Q_W-1) / den), one quotient bit per cycle.
module norm_recip
  import norm_pkg::*;
#(
  parameter int DEN_W = 10,
  parameter int Q_W   = coef_width(DEN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   coef
);

  localparam int CNT_W = $clog2(Q_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic [DEN_W:0]   trial;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    zero_d = zero_q;
    den_d  = den_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    // The dividend is a single 1 in the MSB, so only the first step shifts in a 1.
    trial  = {rem_q, (cnt_q == '0)};
    if (start) begin
      den_d  = den;
      zero_d = (den == '0);
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d = DEN_W'(trial - {1'b0, den_q});
        quo_d = {quo_q[Q_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {quo_q[Q_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(Q_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
      den_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      zero_q <= zero_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign coef = zero_q ? '1 : quo_q;

endmodule

// File: rtl/norm_stream.sv
// Multi-lane pixel normaliser: out = round(pix / den) in fixed point, 2-stage backpressured pipe.
// Build option NORM_STREAM_SAT_EN: overflowing lanes clamp to full scale instead of wrapping.
module norm_stream
  import norm_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int FP_INT          = 5,
  parameter int NUM_LANES       = 4,
  parameter int USER_WIDTH      = 2
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       ap_start,
  input  logic                       cf_ap_done,
  output logic                       ap_ready,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  norm_stream_if.slave               s_axis,
  norm_stream_if.master              m_axis,
  output logic                       ovf_sticky,
  output logic                       div_by_zero
);

  localparam int PW  = PIXEL_BIT_WIDTH;
  localparam int CW  = coef_width(PW);
  localparam int SH  = round_shift(PW, FP_INT);
  localparam int PRW = PW + CW;
  localparam int PSW = PRW + 1;
  localparam int RW  = PSW - SH;
  localparam int DW  = NUM_LANES * PW;
  localparam logic [PSW-1:0] RND = PSW'(1) << (SH - 1);

  norm_state_t state_q, state_d;

  logic                 cf_seen_q, cf_seen_d;
  logic                 ap_ready_q, ap_done_q, idle_q;
  logic                 ovf_q, ovf_d;
  logic                 dbz_q, dbz_d;
  logic                 rc_busy, rc_done;
  logic [CW-1:0]        rc_coef;
  logic                 accept;

  logic                 v1_q, v1_d;
  logic [NUM_LANES*PRW-1:0] prod_q, prod_d;
  logic [USER_WIDTH-1:0] user1_q;
  logic                 last1_q;

  logic                 v2_q, v2_d;
  logic [DW-1:0]        data2_q, lane_out;
  logic [USER_WIDTH-1:0] user2_q;
  logic                 last2_q;
  logic [NUM_LANES-1:0] lane_ovf;

  logic                 ld2, ld1_ok, s_rdy, s_acc, m_acc;

  assign accept = (state_q == ST_IDLE) && ap_start && !rc_busy;

  norm_recip #(
    .DEN_W (PW),
    .Q_W   (CW)
  ) u_recip (
    .clk   (clk),
    .rst_n (s_axis_resetn),
    .start (accept),
    .den   (norm_denominator),
    .busy  (rc_busy),
    .done  (rc_done),
    .coef  (rc_coef)
  );

  // A stage loads when empty or when its consumer drains it this cycle.
  assign m_acc  = v2_q && m_axis.tready;
  assign ld2    = v1_q && (!v2_q || m_axis.tready);
  assign ld1_ok = !v1_q || ld2;
  assign s_rdy  = (state_q == ST_RUN) && ld1_ok;
  assign s_acc  = s_rdy && s_axis.tvalid;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [PSW-1:0] sum;
    logic [RW-1:0]  res;
    assign prod_d[g*PRW +: PRW] = PRW'(s_axis.tdata[g*PW +: PW]) * PRW'(rc_coef);
    assign sum                  = {1'b0, prod_q[g*PRW +: PRW]} + RND;
    assign res                  = RW'(sum >> SH);
    assign lane_ovf[g]          = |res[RW-1:PW];
`ifdef NORM_STREAM_SAT_EN
    assign lane_out[g*PW +: PW] = lane_ovf[g] ? '1 : res[PW-1:0];
`else
    assign lane_out[g*PW +: PW] = res[PW-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept)                    state_d = ST_CALC;
      ST_CALC:    if (rc_done)                   state_d = ST_WAIT_UP;
      ST_WAIT_UP: if (cf_seen_q)                 state_d = ST_RUN;
      ST_RUN:     if (s_acc && s_axis.tlast)     state_d = ST_DRAIN;
      ST_DRAIN:   if (m_acc && last2_q)          state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cf_seen_d = cf_seen_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    // An accept restarts the job; a coincident cf_ap_done still counts for it.
    if (accept) begin
      cf_seen_d = cf_ap_done;
      ovf_d     = 1'b0;
      dbz_d     = (norm_denominator == '0);
    end else begin
      if (cf_ap_done)        cf_seen_d = 1'b1;
      if (ld2 && |lane_ovf)  ovf_d     = 1'b1;
    end
    if (s_acc)      v1_d = 1'b1;
    else if (ld2)   v1_d = 1'b0;
    if (ld2)        v2_d = 1'b1;
    else if (m_acc) v2_d = 1'b0;
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_q    <= ST_IDLE;
      cf_seen_q  <= 1'b0;
      ap_ready_q <= 1'b0;
      ap_done_q  <= 1'b0;
      idle_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
      v1_q       <= 1'b0;
      prod_q     <= '0;
      user1_q    <= '0;
      last1_q    <= 1'b0;
      v2_q       <= 1'b0;
      data2_q    <= '0;
      user2_q    <= '0;
      last2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cf_seen_q  <= cf_seen_d;
      ap_ready_q <= accept;
      ap_done_q  <= (state_q == ST_DRAIN) && m_acc && last2_q;
      idle_q     <= (state_d == ST_IDLE);
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      if (s_acc) begin
        prod_q  <= prod_d;
        user1_q <= s_axis.tuser;
        last1_q <= s_axis.tlast;
      end
      if (ld2) begin
        data2_q <= lane_out;
        user2_q <= user1_q;
        last2_q <= last1_q;
      end
    end
  end

  assign ap_ready      = ap_ready_q;
  assign ap_done       = ap_done_q;
  assign ap_idle       = idle_q;
  assign ovf_sticky    = ovf_q;
  assign div_by_zero   = dbz_q;
  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = v2_q;
  assign m_axis.tdata  = data2_q;
  assign m_axis.tuser  = user2_q;
  assign m_axis.tlast  = last2_q;

endmodule

// File: tb/tb_norm_stream.sv
// Self-checking bench for norm_stream against a plain-arithmetic reference of the scaling rules.
module tb_norm_stream;

  localparam int PW   = 10;
  localparam int FPI  = 5;
  localparam int NL   = 4;
  localparam int UW   = 2;
  localparam int DW   = NL * PW;
  localparam int CF   = 2 * PW;
  localparam int SH   = CF - (PW - FPI);
  localparam longint MAXV = (longint'(1) << PW) - 1;
`ifdef NORM_STREAM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ap_start = 1'b0;
  logic cf = 1'b0;
  logic [PW-1:0] den = '0;
  logic ap_ready, ap_idle, ap_done, ovf, dbz;

  always #5 clk = ~clk;

  norm_stream_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  norm_stream_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  norm_stream #(
    .PIXEL_BIT_WIDTH (PW),
    .FP_INT          (FPI),
    .NUM_LANES       (NL),
    .USER_WIDTH      (UW)
  ) dut (
    .clk              (clk),
    .s_axis_resetn    (rstn),
    .ap_start         (ap_start),
    .cf_ap_done       (cf),
    .ap_ready         (ap_ready),
    .ap_idle          (ap_idle),
    .ap_done          (ap_done),
    .norm_denominator (den),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .ovf_sticky       (ovf),
    .div_by_zero      (dbz)
  );

  int total = 0;
  int bad = 0;
  longint cur_coef;
  bit exp_ovf;
  logic [DW+UW:0] expq[$];
  logic [DW-1:0] last_out;
  int first_s_g;

  function automatic longint coef_of(input int unsigned d);
    if (d == 0) return (longint'(1) << (CF + 1)) - 1;
    return (longint'(1) << CF) / longint'(d);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if ({ap_ready, ap_idle, ap_done, ovf, dbz, s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b idle=%b done=%b ovf=%b dbz=%b str=%b mtv=%b want all 0",
               ap_ready, ap_idle, ap_done, ovf, dbz, s_if.tready, m_if.tvalid);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (ap_idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle: got %b want 1", ap_idle);
    end
  endtask

  task automatic start_job(input int unsigned d, input bit cf_now);
    @(negedge clk);
    ap_start = 1'b1;
    den = PW'(d);
    cf = cf_now;
    #1;
    total++;
    if (ap_idle !== 1'b1) begin
      bad++;
      $display("FAIL start_idle: got %b want 1", ap_idle);
    end
    @(negedge clk);
    ap_start = 1'b0;
    cf = 1'b0;
    #1;
    total++;
    if (ap_ready !== 1'b1) begin
      bad++;
      $display("FAIL ap_ready: got %b want 1", ap_ready);
    end
    total++;
    if ({ovf, dbz} !== {1'b0, (d == 0)}) begin
      bad++;
      $display("FAIL start_flags: got ovf=%b dbz=%b want ovf=0 dbz=%b", ovf, dbz, (d == 0));
    end
    cur_coef = coef_of(d);
    exp_ovf = 1'b0;
    expq.delete();
  endtask

  // Drives one frame of n beats and scoreboards every output handshake.
  task automatic run_stream(input int n, input int fixed_pix, input bit rin, input bit rout,
                            input int cf_at, input bit tput, input bit poke, input int stop_at);
    int idx = 0, cyc = 0, first_s = -1, last_m = -1, got = 0, pend_idx = -1, budget;
    bit prev_last = 1'b0, done_seen = 1'b0, end_hs = 1'b0;
    logic [DW-1:0] pd = '0, ed;
    logic [UW-1:0] pu = '0;
    logic [DW+UW:0] e;
    longint r;
    int unsigned pix;
    budget = n * 12 + 200;
    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      if (pend_idx != idx) begin
        for (int l = 0; l < NL; l++) begin
          pix = (fixed_pix >= 0) ? unsigned'(fixed_pix) : $urandom_range(0, 1023);
          pd[l*PW +: PW] = pix[PW-1:0];
        end
        pu = UW'($urandom);
        pend_idx = idx;
      end
      cf           = (cyc == cf_at);
      ap_start     = poke && !end_hs && ($urandom_range(0, 3) == 0);
      s_if.tvalid  = (idx < n) && (!rin || $urandom_range(0, 1) == 1);
      s_if.tdata   = pd;
      s_if.tuser   = pu;
      s_if.tlast   = (idx == n - 1);
      m_if.tready  = !rout || ($urandom_range(0, 2) != 0);
      #1;
      if (cyc < 19) begin
        total++;
        if (s_if.tready !== 1'b0) begin
          bad++;
          $display("FAIL early_tready: cycle %0d got %b want 0", cyc, s_if.tready);
        end
      end
      total++;
      if (ap_ready !== 1'b0) begin
        bad++;
        $display("FAIL start_ignored: cycle %0d ap_ready got %b want 0", cyc, ap_ready);
      end
      total++;
      if (ap_done !== prev_last) begin
        bad++;
        $display("FAIL ap_done: cycle %0d got %b want %b", cyc, ap_done, prev_last);
      end
      done_seen = prev_last || (ap_done === 1'b1);
      prev_last = 1'b0;
      if (s_if.tvalid && s_if.tready) begin
        for (int l = 0; l < NL; l++) begin
          r = (longint'(pd[l*PW +: PW]) * cur_coef + (longint'(1) << (SH - 1))) >> SH;
          if (r > MAXV) exp_ovf = 1'b1;
          ed[l*PW +: PW] = (SAT && r > MAXV) ? PW'(MAXV) : PW'(r);
        end
        expq.push_back({s_if.tlast, pu, ed});
        if (first_s < 0) first_s = cyc;
        idx++;
      end
      if (m_if.tvalid && m_if.tready) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got %h want none", m_if.tdata);
        end else begin
          e = expq.pop_front();
          if ({m_if.tlast, m_if.tuser, m_if.tdata} !== e) begin
            bad++;
            $display("FAIL beat %0d: got %h want %h", got, {m_if.tlast, m_if.tuser, m_if.tdata}, e);
          end
        end
        last_out = m_if.tdata;
        got++;
        last_m = cyc;
        if (m_if.tlast) begin
          prev_last = 1'b1;
          end_hs = 1'b1;
        end
      end
      cyc++;
      if (stop_at >= 0 && cyc >= stop_at) break;
    end
    s_if.tvalid = 1'b0;
    ap_start = 1'b0;
    cf = 1'b0;
    first_s_g = first_s;
    if (stop_at < 0) begin
      total++;
      if (!done_seen) begin
        bad++;
        $display("FAIL timeout: no ap_done within %0d cycles", budget);
      end
      total++;
      if (got != n) begin
        bad++;
        $display("FAIL beat_count: got %0d want %0d", got, n);
      end
      total++;
      if (ap_idle !== 1'b1) begin
        bad++;
        $display("FAIL end_idle: got %b want 1", ap_idle);
      end
      total++;
      if (ovf !== exp_ovf) begin
        bad++;
        $display("FAIL ovf_sticky: got %b want %b", ovf, exp_ovf);
      end
      if (tput) begin
        total++;
        if (last_m - first_s != n + 1) begin
          bad++;
          $display("FAIL throughput: span got %0d want %0d", last_m - first_s, n + 1);
        end
      end
    end
  endtask

  task automatic test_basic();
    start_job(4, 1'b0);
    run_stream(1, 8, 1'b0, 1'b0, 25, 1'b0, 1'b0, -1);
    total++;
    if (last_out !== {NL{10'd64}}) begin
      bad++;
      $display("FAIL basic_den4: got %h want %h", last_out, {NL{10'd64}});
    end
  endtask

  task automatic test_rounding();
    logic [PW-1:0] want;
    start_job(3, 1'b0);
    run_stream(1, 1, 1'b0, 1'b0, 24, 1'b0, 1'b0, -1);
    total++;
    if (last_out[PW-1:0] !== 10'd11) begin
      bad++;
      $display("FAIL round_den3: got %0d want 11", last_out[PW-1:0]);
    end
    start_job(1, 1'b0);
    run_stream(1, 1023, 1'b0, 1'b0, 24, 1'b0, 1'b0, -1);
    want = SAT ? 10'd1023 : 10'd992;
    total++;
    if (last_out[PW-1:0] !== want) begin
      bad++;
      $display("FAIL ovf_den1: got %0d want %0d", last_out[PW-1:0], want);
    end
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_den1_flag: got %b want 1", ovf);
    end
  endtask

  task automatic test_div_zero();
    start_job(0, 1'b1);
    run_stream(4, 500, 1'b0, 1'b1, -1, 1'b0, 1'b0, -1);
    total++;
    if (dbz !== 1'b1) begin
      bad++;
      $display("FAIL div_by_zero: got %b want 1", dbz);
    end
    start_job(5, 1'b0);
    run_stream(8, -1, 1'b1, 1'b0, 22, 1'b0, 1'b0, -1);
  endtask

  task automatic test_cf_during_calc();
    start_job(7, 1'b0);
    run_stream(16, -1, 1'b0, 1'b0, 5, 1'b1, 1'b0, -1);
    total++;
    if (first_s_g < 19 || first_s_g > 24) begin
      bad++;
      $display("FAIL stream_start: first accept cycle got %0d want 19..24", first_s_g);
    end
  endtask

  task automatic test_backpressure();
    start_job($urandom_range(1, 40), 1'b0);
    run_stream(64, -1, 1'b1, 1'b1, 30, 1'b0, 1'b1, -1);
  endtask

  task automatic test_midframe_reset();
    start_job(0, 1'b1);
    run_stream(64, 600, 1'b0, 1'b1, -1, 1'b0, 1'b0, 35);
    rstn = 1'b0;
    #1;
    total++;
    if ({ap_ready, ap_idle, ap_done, ovf, dbz, s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== '0) begin
      bad++;
      $display("FAIL midframe_reset: got idle=%b ovf=%b dbz=%b mtv=%b data=%h want all 0",
               ap_idle, ovf, dbz, m_if.tvalid, m_if.tdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    start_job(9, 1'b0);
    run_stream(10, -1, 1'b1, 1'b1, 0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_div_zero();
    test_cf_during_calc();
    test_backpressure();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
